// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 memory responder
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        IO     = 2'd2,
        RESP   = 2'd3
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous board inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - SLC-3 load/store responder for async SRAM and memory-mapped I/O
module mem_io_responder
    import slc3_mem_pkg::*;
#(
    parameter int              ADDR_W      = 16,
    parameter int              DATA_W      = 16,
    parameter int              WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(IO_ADDR_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic [DATA_W-1:0] Switches,
    output logic [DATA_W-1:0] HEX_OUT,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("mem_io_responder: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    mem_state_t       state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             we_q;
    logic [DATA_W-1:0] sw_sync;
    logic             accept;
    logic             is_io;

    sync_2ff #(.WIDTH(DATA_W)) u_sw_sync (
        .clk    (Clk),
        .resetn (Reset),
        .d      (Switches),
        .q      (sw_sync)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign is_io     = (req_addr == IO_ADDR);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = is_io ? IO : ACCESS;
            ACCESS:  if (wait_cnt == '0) next_state = RESP;
            IO:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are set on the accept edge and cleared on the last ACCESS edge,
    // so they are flop outputs and the read sample happens while oe_n is still low.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wait_cnt   <= '0;
            we_q       <= 1'b0;
            rsp_rdata  <= '0;
            HEX_OUT    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q       <= req_we;
                        sram_wdata <= req_wdata;
                        if (!is_io) begin
                            sram_addr  <= req_addr;
                            wait_cnt   <= CNT_LOAD;
                            sram_ce_n  <= 1'b0;
                            sram_oe_n  <= req_we;
                            sram_we_n  <= !req_we;
                            sram_dq_oe <= req_we;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        if (!we_q) rsp_rdata <= sram_rdata;
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                IO: begin
                    if (we_q) HEX_OUT <= sram_wdata;
                    else      rsp_rdata <= sw_sync;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder
module tb_mem_io_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid, req_valid_b, req_we;
    logic [15:0] req_addr, req_wdata, Switches;

    logic        req_ready, rsp_valid, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [15:0] rsp_rdata, HEX_OUT, sram_addr, sram_wdata, sram_rdata;

    logic        req_ready_1, rsp_valid_1, dq_oe_1, ce_n_1, oe_n_1, we_n_1;
    logic [15:0] rsp_rdata_1, hex_1, addr_1, wdata_1, rdata_1;
    logic        req_ready_5, rsp_valid_5, dq_oe_5, ce_n_5, oe_n_5, we_n_5;
    logic [15:0] rsp_rdata_5, hex_5, addr_5, wdata_5, rdata_5;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    always #5 Clk = ~Clk;

    mem_io_responder #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .Switches(Switches),
        .HEX_OUT(HEX_OUT), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mem_io_responder #(.WAIT_CYCLES(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_1),
        .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .Switches(Switches),
        .HEX_OUT(hex_1), .sram_addr(addr_1), .sram_wdata(wdata_1),
        .sram_rdata(rdata_1), .sram_dq_oe(dq_oe_1), .sram_ce_n(ce_n_1),
        .sram_oe_n(oe_n_1), .sram_we_n(we_n_1)
    );

    mem_io_responder #(.WAIT_CYCLES(5)) dut_w5 (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_5),
        .rsp_valid(rsp_valid_5), .rsp_rdata(rsp_rdata_5), .Switches(Switches),
        .HEX_OUT(hex_5), .sram_addr(addr_5), .sram_wdata(wdata_5),
        .sram_rdata(rdata_5), .sram_dq_oe(dq_oe_5), .sram_ce_n(ce_n_5),
        .sram_oe_n(oe_n_5), .sram_we_n(we_n_5)
    );

    // Async SRAM model for the main instance; fixed pattern for the latency instances.
    always @(posedge Clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_wdata;
    end
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;
    assign rdata_1    = (!ce_n_1 && !oe_n_1) ? (addr_1 ^ 16'hC3C3) : 16'hDEAD;
    assign rdata_5    = (!ce_n_5 && !oe_n_5) ? (addr_5 ^ 16'hC3C3) : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, mon_exp});
            end
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        int          lat;
        int          strobe_cyc;
        logic [15:0] exp_rd;
        logic [15:0] exp_hex;
    } vec_t;

    vec_t vecs [9];

    task automatic wait_ready();
        int n = 0;
        @(negedge Clk);
        while (!req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat = 0, ce_low = 0, we_low = 0, addr_bad = 0, ready_bad = 0;
        Switches = v.sw;
        repeat (3) @(negedge Clk);
        wait_ready();
        exp_q.push_back(v.exp_rd);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge Clk);
            lat++;
            if (!sram_ce_n) begin
                ce_low++;
                if (sram_addr !== v.addr) addr_bad++;
            end
            if (!sram_we_n) we_low++;
            if (req_ready) ready_bad++;
        end while (!rsp_valid && lat < 20);
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_ce_low_cycles", idx), ce_low, v.strobe_cyc);
        check($sformatf("v%0d_we_low_cycles", idx), we_low, v.we ? v.strobe_cyc : 0);
        check($sformatf("v%0d_addr_unstable", idx), addr_bad, 0);
        check($sformatf("v%0d_ready_while_busy", idx), ready_bad, 0);
        @(negedge Clk);
        check($sformatf("v%0d_hex_out", idx), {16'h0, HEX_OUT}, {16'h0, v.exp_hex});
        check($sformatf("v%0d_ready_after_resp", idx), {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int accepts, pulses, last, spacing_bad, ready_busy;
        int lat1, lat5, ce1, ce5, abad;
        logic [15:0] d1, d5;

        //          we    addr      wdata     sw        lat s  exp_rd    exp_hex
        vecs[0] = '{1'b1, 16'h0040, 16'h1234, 16'h0000, 3, 2, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 16'h0040, 16'h0000, 16'h0000, 3, 2, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h00AB, 16'h0000, 2, 0, 16'h1234, 16'h00AB};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, 2, 0, 16'h5A5A, 16'h00AB};
        vecs[4] = '{1'b0, 16'hFFFE, 16'h0000, 16'h5A5A, 3, 2, 16'hBEEF, 16'h00AB};
        vecs[5] = '{1'b1, 16'hFFFE, 16'h7777, 16'h0000, 3, 2, 16'hBEEF, 16'h00AB};
        vecs[6] = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 3, 2, 16'h7777, 16'h00AB};
        vecs[7] = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5C3, 2, 0, 16'hA5C3, 16'h00AB};
        vecs[8] = '{1'b1, 16'hFFFF, 16'h0F0F, 16'h0000, 2, 0, 16'hA5C3, 16'h0F0F};

        mem[16'hFFFE] = 16'hBEEF;
        Reset = 1'b0;
        req_valid = 1'b0; req_valid_b = 1'b0; req_we = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; Switches = 16'h0;
        repeat (3) @(negedge Clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
        check("rst_hex_out", {16'h0, HEX_OUT}, 32'd0);
        check("rst_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        check("rst_sram_addr", {16'h0, sram_addr}, 32'd0);
        Reset = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an SRAM write
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100; req_wdata = 16'h5555;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(negedge Clk);
        check("midwr_ce_asserted", {30'h0, sram_ce_n, sram_we_n}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        check("midrst_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        check("midrst_req_ready", {31'h0, req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("midrst_hex_out", {16'h0, HEX_OUT}, 32'd0);
        check("midrst_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        check("postrst_queue_empty", exp_q.size(), 0);

        // Back-to-back reads with req_valid held high
        wait_ready();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1234);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
        accepts = 0; pulses = 0; last = -1; spacing_bad = 0; ready_busy = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge Clk);
            if (rsp_valid) begin
                if (last >= 0 && (cyc - last) != 4) spacing_bad++;
                last = cyc;
                pulses++;
            end
            if (req_ready && (rsp_valid || !sram_ce_n)) ready_busy++;
            if (req_valid && req_ready) begin
                accepts++;
                if (accepts == 4) begin
                    @(posedge Clk);
                    #1 req_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", accepts, 4);
        check("b2b_pulses", pulses, 4);
        check("b2b_spacing", spacing_bad, 0);
        check("b2b_ready_busy", ready_busy, 0);
        check("b2b_queue_drained", exp_q.size(), 0);

        // Latency of WAIT_CYCLES=1 and WAIT_CYCLES=5 builds
        @(negedge Clk);
        req_valid_b = 1'b1; req_we = 1'b0; req_addr = 16'h0123;
        @(posedge Clk);
        #1 req_valid_b = 1'b0;
        lat1 = 0; lat5 = 0; ce1 = 0; ce5 = 0; abad = 0; d1 = 16'h0; d5 = 16'h0;
        for (int l = 1; l <= 20 && (lat1 == 0 || lat5 == 0); l++) begin
            @(negedge Clk);
            if (!ce_n_1) begin ce1++; if (addr_1 !== 16'h0123) abad++; end
            if (!ce_n_5) begin ce5++; if (addr_5 !== 16'h0123) abad++; end
            if (rsp_valid_1 && lat1 == 0) begin lat1 = l; d1 = rsp_rdata_1; end
            if (rsp_valid_5 && lat5 == 0) begin lat5 = l; d5 = rsp_rdata_5; end
        end
        check("w1_latency", lat1, 2);
        check("w5_latency", lat5, 6);
        check("w1_ce_cycles", ce1, 1);
        check("w5_ce_cycles", ce5, 5);
        check("w1_rdata", {16'h0, d1}, 32'h0000C2E0);
        check("w5_rdata", {16'h0, d5}, 32'h0000C2E0);
        check("w15_addr_stable", abad, 0);

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
